// File: rtl/univ_cnt_sequencer.sv
// univ_cnt_sequencer
// Turns a stream of commands (clear, load, count down, count up) into
// registered control pulses for an N-bit universal counter. Each command
// starts driving the counter in the cycle after it is accepted.
//
// Configuration macro: CNT_SEQ_CMD_FIFO_EN
//   undefined : one command at a time. cmd_ready_o is high only while idle,
//               so there is one idle cycle between consecutive commands.
//   defined   : 4-entry command FIFO. Queued commands run back-to-back with
//               no gap cycle, in the order they were accepted.
//
// Parameters
//   N : width of the controlled counter and of d_o
//   C : width of cmd_arg_i and of the internal cycle counter (C >= N)
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   cmd_valid_i  command offered this cycle
//   cmd_ready_o  sequencer accepts the offered command this cycle
//   cmd_op_i     00 CLR, 01 LOAD, 10 COUNT_DOWN, 11 COUNT_UP
//   cmd_arg_i    LOAD: value in [N-1:0]; COUNT_*: number of cycles
//   syn_clr_o    counter synchronous clear
//   load_o       counter parallel load
//   en_o         counter enable
//   up_o         counter direction (1 = up)
//   d_o          counter load data
//   busy_o       a command is executing or queued
//   done_o       one-cycle pulse in the final cycle of each command
module univ_cnt_sequencer #(
  parameter int N = 3,
  parameter int C = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [1:0]   cmd_op_i,
  input  logic [C-1:0] cmd_arg_i,
  output logic         syn_clr_o,
  output logic         load_o,
  output logic         en_o,
  output logic         up_o,
  output logic [N-1:0] d_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    LOAD  = 2'd2,
    COUNT = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [C-1:0] cycleCnt_q, cycleCnt_d;
  logic         dir_q, dir_d;

  logic         synClr_q, synClr_d;
  logic         load_q, load_d;
  logic         en_q, en_d;
  logic         up_q, up_d;
  logic [N-1:0] data_q, data_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic         push;
  logic         finishing;
  logic         startReq;
  logic [1:0]   startOp;
  logic [C-1:0] startArg;
  logic         queueBusy;

  // cycleCnt_q holds the number of enable cycles still to run, including
  // the current one, so a COUNT command is in its last cycle at 1 (or 0
  // for a zero-length count).
  assign finishing = (state_q == CLR) || (state_q == LOAD) ||
                     ((state_q == COUNT) && (cycleCnt_q <= C'(1)));

`ifdef CNT_SEQ_CMD_FIFO_EN
  // The executing command stays at the FIFO head until its final cycle, so
  // occupancy counts it too; this is what limits the sequencer to four
  // outstanding commands.
  logic [1:0]   fifoOp_q  [4];
  logic [C-1:0] fifoArg_q [4];
  logic [1:0]   wrPtr_q, wrPtr_d;
  logic [1:0]   rdPtr_q, rdPtr_d;
  logic [2:0]   count_q, count_d;
  logic [1:0]   rdNext;
  logic         pop;

  assign cmd_ready_o = !rst_i && (count_q != 3'd4);
  assign push        = cmd_valid_i && cmd_ready_o;
  assign rdNext      = rdPtr_q + 2'd1;
  assign pop         = finishing;

  // A new command starts either from the entry behind the head, or straight
  // from the input when nothing else is waiting, so it never loses a cycle.
  always_comb begin
    startReq = 1'b0;
    startOp  = cmd_op_i;
    startArg = cmd_arg_i;
    if (state_q == IDLE) begin
      startReq = push;
    end else if (finishing) begin
      if (count_q >= 3'd2) begin
        startReq = 1'b1;
        startOp  = fifoOp_q[rdNext];
        startArg = fifoArg_q[rdNext];
      end else begin
        startReq = push;
      end
    end
    wrPtr_d   = wrPtr_q + {1'b0, push};
    rdPtr_d   = rdPtr_q + {1'b0, pop};
    count_d   = count_q + {2'b00, push} - {2'b00, pop};
    queueBusy = (count_d != 3'd0);
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= 2'd0;
      rdPtr_q <= 2'd0;
      count_q <= 3'd0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // FIFO storage needs no reset; only entries below the occupancy are read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifoOp_q[wrPtr_q]  <= cmd_op_i;
      fifoArg_q[wrPtr_q] <= cmd_arg_i;
    end
  end
`else
  assign cmd_ready_o = !rst_i && (state_q == IDLE);
  assign push        = cmd_valid_i && cmd_ready_o;

  // Commands are only accepted while idle, so an accepted command always
  // starts right away from the input.
  always_comb begin
    startReq  = push;
    startOp   = cmd_op_i;
    startArg  = cmd_arg_i;
    queueBusy = 1'b0;
  end
`endif

  // Next-state logic. The control outputs are derived from the next state
  // so that they can be registered and still line up with the state.
  always_comb begin
    state_d    = state_q;
    cycleCnt_d = cycleCnt_q;
    dir_d      = dir_q;
    data_d     = '0;

    case (state_q)
      IDLE: ;
      CLR,
      LOAD: state_d = IDLE;
      COUNT: begin
        if (finishing) begin
          state_d    = IDLE;
          cycleCnt_d = '0;
        end else begin
          cycleCnt_d = cycleCnt_q - C'(1);
        end
      end
    endcase

    if (startReq) begin
      case (startOp)
        2'b00: begin
          state_d    = CLR;
          cycleCnt_d = '0;
        end
        2'b01: begin
          state_d    = LOAD;
          cycleCnt_d = '0;
          data_d     = startArg[N-1:0];
        end
        default: begin
          state_d    = COUNT;
          cycleCnt_d = startArg;
          dir_d      = startOp[0];
        end
      endcase
    end

    synClr_d = (state_d == CLR);
    load_d   = (state_d == LOAD);
    en_d     = (state_d == COUNT) && (cycleCnt_d != '0);
    up_d     = en_d && dir_d;
    done_d   = (state_d == CLR) || (state_d == LOAD) ||
               ((state_d == COUNT) && (cycleCnt_d <= C'(1)));
    busy_d   = (state_d != IDLE) || queueBusy;
  end

  // State and registered outputs. Reset drops everything, including an
  // in-flight command, without a done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cycleCnt_q <= '0;
      dir_q      <= 1'b0;
      synClr_q   <= 1'b0;
      load_q     <= 1'b0;
      en_q       <= 1'b0;
      up_q       <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycleCnt_q <= cycleCnt_d;
      dir_q      <= dir_d;
      synClr_q   <= synClr_d;
      load_q     <= load_d;
      en_q       <= en_d;
      up_q       <= up_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign syn_clr_o = synClr_q;
  assign load_o    = load_q;
  assign en_o      = en_q;
  assign up_o      = up_q;
  assign d_o       = data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_univ_cnt_sequencer.sv
// tb_univ_cnt_sequencer
// Self-checking bench for univ_cnt_sequencer. A timeline model keeps, per
// future cycle, the output pattern every accepted command must produce; an
// N-bit counter driven by the DUT outputs is compared with the arithmetic
// effect of those commands. Works for both settings of CNT_SEQ_CMD_FIFO_EN.
module tb_univ_cnt_sequencer;

  localparam int N = 3;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmdValid;
  logic         cmdReady;
  logic [1:0]   cmdOp;
  logic [C-1:0] cmdArg;
  logic         synClr;
  logic         loadSig;
  logic         enSig;
  logic         upSig;
  logic [N-1:0] dOut;
  logic         busySig;
  logic         doneSig;

  univ_cnt_sequencer #(.N(N), .C(C)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmdValid),
    .cmd_ready_o (cmdReady),
    .cmd_op_i    (cmdOp),
    .cmd_arg_i   (cmdArg),
    .syn_clr_o   (synClr),
    .load_o      (loadSig),
    .en_o        (enSig),
    .up_o        (upSig),
    .d_o         (dOut),
    .busy_o      (busySig),
    .done_o      (doneSig)
  );

  always #5 clk = ~clk;

  // Expected outputs of one cycle.
  typedef struct packed {
    logic         clr;
    logic         ld;
    logic         en;
    logic         up;
    logic [N-1:0] d;
    logic         done;
  } rec_t;

  // sched[0] is the expected pattern for the current cycle.
  rec_t         sched[$];
  int           total = 0;
  int           bad = 0;
  logic [N-1:0] benchCnt;
  logic [N-1:0] modelCnt;

  // The controlled counter, driven only by the sequencer outputs.
  always_ff @(posedge clk) begin
    if (rst)          benchCnt <= '0;
    else if (synClr)  benchCnt <= '0;
    else if (loadSig) benchCnt <= dOut;
    else if (enSig)   benchCnt <= upSig ? benchCnt + N'(1) : benchCnt - N'(1);
  end

  function automatic int outstanding();
    int n = 0;
    foreach (sched[i]) if (sched[i].done) n++;
    return n;
  endfunction

  function automatic logic modelReady(input logic r);
    if (r) return 1'b0;
`ifdef CNT_SEQ_CMD_FIFO_EN
    return outstanding() < 4;
`else
    return sched.size() == 0;
`endif
  endfunction

  // Expand an accepted command into its per-cycle output patterns.
  task automatic appendCmd(input logic [1:0] op, input logic [C-1:0] arg);
    rec_t r;
    r = '0;
    if (op == 2'b00) begin
      r.clr = 1'b1; r.done = 1'b1; sched.push_back(r);
    end else if (op == 2'b01) begin
      r.ld = 1'b1; r.d = arg[N-1:0]; r.done = 1'b1; sched.push_back(r);
    end else if (arg == '0) begin
      r.done = 1'b1; sched.push_back(r);
    end else begin
      for (int k = 0; k < int'(arg); k++) begin
        r = '0;
        r.en = 1'b1;
        r.up = op[0];
        r.done = (k == int'(arg) - 1);
        sched.push_back(r);
      end
    end
  endtask

  task automatic applyEffect(input rec_t r);
    if (r.clr)     modelCnt = '0;
    else if (r.ld) modelCnt = r.d;
    else if (r.en) modelCnt = r.up ? modelCnt + N'(1) : modelCnt - N'(1);
  endtask

  task automatic checkOutput();
    rec_t e;
    logic [N+5:0] act;
    logic [N+5:0] exp;
    e = '0;
    if (sched.size() != 0) e = sched[0];
    act = {synClr, loadSig, enSig, upSig, dOut, doneSig, busySig};
    exp = {e, (sched.size() != 0)};
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL outputs t=%0t clr/ld/en/up/d/done/busy got=%b required=%b", $time, act, exp);
    end
    total++;
    if (benchCnt !== modelCnt) begin
      bad++;
      $display("[TB] FAIL counter t=%0t got=%0d required=%0d", $time, benchCnt, modelCnt);
    end
  endtask

  task automatic checkLiteral(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check ready, advance model, check outputs.
  task automatic applyStimulus(input logic r, input logic v, input logic [1:0] op,
                               input logic [C-1:0] arg, output logic acc);
    logic expReady;
    rst = r; cmdValid = v; cmdOp = op; cmdArg = arg;
    #1;
    expReady = modelReady(r);
    total++;
    if (cmdReady !== expReady) begin
      bad++;
      $display("[TB] FAIL ready t=%0t got=%b required=%b", $time, cmdReady, expReady);
    end
    acc = v && expReady;
    @(posedge clk);
    #1;
    if (r) begin
      sched.delete();
      modelCnt = '0;
    end else begin
      if (sched.size() != 0) begin
        applyEffect(sched[0]);
        void'(sched.pop_front());
      end
      if (acc) appendCmd(op, arg);
    end
    checkOutput();
  endtask

  task automatic idleCycle();
    logic acc;
    applyStimulus(1'b0, 1'b0, 2'b00, '0, acc);
  endtask

  task automatic issueCmd(input logic [1:0] op, input logic [C-1:0] arg);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 3000) begin
      applyStimulus(1'b0, 1'b1, op, arg, acc);
      n++;
    end
    total++;
    if (!acc) begin
      bad++;
      $display("[TB] FAIL issue_timeout op=%0d got=not_accepted required=accepted", op);
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (sched.size() != 0 && n < 3000) begin
      idleCycle();
      n++;
    end
    total++;
    if (sched.size() != 0) begin
      bad++;
      $display("[TB] FAIL idle_timeout got=%0d required=0 pending cycles", sched.size());
    end
  endtask

  initial begin
    logic acc;
    int accCount;
    int expAcc;

    rst = 1'b1; cmdValid = 1'b0; cmdOp = 2'b00; cmdArg = '0;
    modelCnt = '0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 2'b00, '0, acc);
    checkLiteral("reset_busy", int'(busySig), 0);
    idleCycle();

    // COUNT_UP 10 from 0 ends at 2.
    issueCmd(2'b11, C'(10));
    waitIdle();
    checkLiteral("up10_counter", int'(benchCnt), 2);
    checkLiteral("up10_model", int'(modelCnt), 2);

    // LOAD 5 then COUNT_DOWN 7 ends at 6.
    issueCmd(2'b01, C'(5));
    issueCmd(2'b10, C'(7));
    waitIdle();
    checkLiteral("load5_down7_counter", int'(benchCnt), 6);
    checkLiteral("load5_down7_model", int'(modelCnt), 6);

    // CLR then COUNT_UP 4 ends at 4.
    issueCmd(2'b00, '0);
    issueCmd(2'b11, C'(4));
    waitIdle();
    checkLiteral("clr_up4_counter", int'(benchCnt), 4);

    // Zero-length count leaves the counter alone.
    issueCmd(2'b11, '0);
    waitIdle();
    checkLiteral("up0_counter", int'(benchCnt), 4);
    checkLiteral("up0_busy", int'(busySig), 0);

    // Reset in the third enable cycle of COUNT_DOWN 7 aborts it.
    issueCmd(2'b10, C'(7));
    idleCycle();
    idleCycle();
    applyStimulus(1'b1, 1'b1, 2'b11, C'(3), acc);
    checkLiteral("abort_en", int'(enSig), 0);
    checkLiteral("abort_done", int'(doneSig), 0);
    checkLiteral("abort_busy", int'(busySig), 0);
    idleCycle();
    issueCmd(2'b01, C'(7));
    waitIdle();
    checkLiteral("abort_load7_counter", int'(benchCnt), 7);

    // Longest count: 255 cycles, 7 + 255 = 262 -> 6.
    issueCmd(2'b11, C'(255));
    waitIdle();
    checkLiteral("up255_counter", int'(benchCnt), 6);

    // Five COUNT_UP 5 offered back-to-back.
    issueCmd(2'b00, '0);
    waitIdle();
`ifdef CNT_SEQ_CMD_FIFO_EN
    expAcc = 4;
`else
    expAcc = 1;
`endif
    accCount = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 2'b11, C'(5), acc);
      if (acc) accCount++;
    end
    checkLiteral("burst_accepted", accCount, expAcc);
    for (int i = accCount; i < 5; i++) issueCmd(2'b11, C'(5));
    waitIdle();
    checkLiteral("burst_counter", int'(benchCnt), 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      logic r;
      logic v;
      logic [1:0] op;
      logic [C-1:0] arg;
      r   = ($urandom_range(0, 79) == 0);
      v   = ($urandom_range(0, 2) != 0);
      op  = 2'($urandom_range(0, 3));
      arg = ($urandom_range(0, 7) == 0) ? C'($urandom_range(0, 60)) : C'($urandom_range(0, 6));
      applyStimulus(r, v, op, arg, acc);
    end
    waitIdle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/univ_cnt_sequencer.md
UNIV_CNT_SEQUENCER -- requirements
Module: univ_cnt_sequencer

Interface
REQ-001 Parameter N, default 3, width of the controlled counter and of d.
REQ-002 Parameter C, default 8, width of cmd_arg; C >= N SHALL hold.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid  in  1  command offered this cycle.
REQ-006 cmd_ready  out  1  sequencer accepts command this cycle.
REQ-007 cmd_op  in  2  opcode: 00 CLR, 01 LOAD, 10 COUNT_DOWN, 11 COUNT_UP.
REQ-008 cmd_arg  in  C  LOAD: value in bits [N-1:0]; COUNT_*: cycle count; CLR: ignored.
REQ-009 syn_clr  out  1  counter synchronous clear.
REQ-010 load  out  1  counter parallel load.
REQ-011 en  out  1  counter enable.
REQ-012 up  out  1  counter direction, 1 = up.
REQ-013 d  out  N  counter load data.
REQ-014 busy  out  1  command executing or queued.
REQ-015 done  out  1  one-cycle pulse in the final cycle of each command.

Function
REQ-016 Command SHALL be accepted on a rising edge where cmd_valid && cmd_ready; op and arg captured at that edge.
REQ-017 All counter-control outputs (syn_clr, load, en, up, d) and done SHALL be registered; first control cycle of an accepted command is the cycle after acceptance.
REQ-018 FSM states: IDLE, CLR, LOAD, COUNT; IDLE -> CLR/LOAD/COUNT on command start; each returns to IDLE, or directly to the next command's state if one is queued (FIFO build).
REQ-019 CLR: syn_clr=1 for exactly 1 cycle, done=1 in that cycle.
REQ-020 LOAD: load=1 and d=arg[N-1:0] for exactly 1 cycle, done=1 in that cycle.
REQ-021 COUNT_*: en=1, up=op[0] for exactly arg consecutive cycles; done=1 in the last en cycle.
REQ-022 COUNT_* with arg=0: one cycle in COUNT with en=0, done=1; counter untouched.
REQ-023 At most one of syn_clr, load, en SHALL be 1 in any cycle.
REQ-024 d=0 whenever load=0; up=0 whenever en=0.
REQ-025 Internal cycle counter is C bits; arg=2^C-1 SHALL produce exactly 2^C-1 en cycles, no wrap.
REQ-026 busy=1 when state != IDLE or queued commands exist; else 0.
REQ-027 cmd_ready SHALL not depend combinationally on cmd_valid.

Reset
REQ-028 rst=1 at an edge: state IDLE, queue emptied, cycle counter 0; syn_clr, load, en, up, d, done, busy = 0 from the following cycle.
REQ-029 rst mid-command SHALL abort it with no done pulse; commands offered while rst=1 are discarded.
REQ-030 cmd_ready=0 during rst=1 cycles, reflects REQ-031/REQ-032 the cycle after rst falls.

Configuration
REQ-031 Macro CNT_SEQ_CMD_FIFO_EN undefined: single command register; cmd_ready = (state==IDLE); one idle cycle between consecutive commands.
REQ-032 CNT_SEQ_CMD_FIFO_EN defined: 4-entry command FIFO; cmd_ready = FIFO not full (registered occupancy); a queued command starts the cycle after the previous done, no bubble; no push when full even if a pop occurs in that cycle; command order preserved.

Verification
REQ-033 Reset then COUNT_UP arg=10 -> en=1, up=1 for 10 cycles, done on 10th, 3-bit counter ends at 2.
REQ-034 LOAD arg=5 then COUNT_DOWN arg=7 -> load=1, d=5 one cycle; en=1, up=0 seven cycles; counter ends at 6.
REQ-035 CLR, then COUNT_UP arg=4 -> syn_clr one cycle, counter 0, then counts to 4; syn_clr/load/en never overlap.
REQ-036 COUNT_UP arg=0 -> en stays 0, done pulses once, busy returns 0.
REQ-037 rst asserted on 3rd cycle of COUNT_DOWN arg=7 -> en=0 next cycle, no done, busy=0; then LOAD arg=7 executes normally.
REQ-038 FIFO build: 5 commands offered back-to-back -> 4 accepted, cmd_ready=0 until first done; all execute in order with no gap cycles.
